mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Multi-cycle load/store controller between the execute stage and data memory.
//  Takes byte address, store data and RISC-V funct3, runs a req/ready handshake with data memory,
//  and registers the read word as dmem_out with matching load_type for the writeback data selector.
//  Stalls the core (busy) until the access finishes, faults, or times out.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles in REQ without mem_ready before abort; must be >=1
//  CNT_W           8    timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clk         in   1   clock, rising edge
//  rst_n       in   1   asynchronous reset, active low
//  start       in   1   access request from execute; sampled only in IDLE
//  is_store    in   1   1=store, 0=load (sampled with start)
//  funct3      in   3   0=B 1=H 2=W 4=BU 5=HU (sampled with start)
//  addr        in   32  byte address (alu_out)
//  store_data  in   32  rs2 value, low bits significant
//  busy        out  1   high from start-accept cycle until done; stalls pipeline
//  done        out  1   one-cycle pulse: access finished (success or error)
//  err_align   out  1   valid with done: misaligned or illegal funct3, no memory access made
//  err_timeout out  1   valid with done: memory did not respond
//  dmem_out    out  32  registered raw read word; held until next load completes
//  load_type   out  7   writeback parse code, registered with dmem_out
//  mem_req     out  1   memory request, registered
//  mem_we      out  1   write enable, valid while mem_req
//  mem_addr    out  30  word address = addr[31:2]
//  mem_be      out  4   byte-lane enables
//  mem_wdata   out  32  lane-aligned write data
//  mem_ready   in   1   memory accepts/completes the access in a cycle where mem_req=1
//  mem_rdata   in   32  read word, valid when mem_req&&mem_ready&&!mem_we
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; all outputs 0; counter 0. Reset mid-access drops mem_req at once; no done.
//  - FSM IDLE->REQ->DONE->IDLE; IDLE->DONE directly on alignment fault.
//  - IDLE: on start, latch is_store/funct3/addr/store_data; busy=1 next cycle.
//    Fault if funct3 in {3,6,7}, H/HU with addr[0]=1, W with addr[1:0]!=0 -> DONE, err_align=1, mem_req never set.
//  - REQ: mem_req=1; mem_addr/we/be/wdata stable until handshake. mem_ready=1 ends it at that edge:
//    load captures mem_rdata->dmem_out and load_type; store updates neither. -> DONE.
//  - Timeout: counter +1 per REQ cycle without ready; at TIMEOUT_CYCLES drop mem_req, err_timeout=1, -> DONE.
//  - DONE: done=1 for one cycle, busy=0 in that cycle, errors valid; -> IDLE. Flags clear next cycle.
//  - start outside IDLE is ignored; start in the DONE cycle is ignored.
//  - Latency: start edge n -> mem_req cycle n+1; ready in n+1 -> done in n+2. Fault: done in n+1.
//  - Byte lane k=addr[1:0]. Store B: be=1<<k, wdata=store_data[7:0] replicated x4.
//    Store H: be=addr[1]?4'b1100:4'b0011, wdata={2{store_data[15:0]}}. Store W: be=4'hF.
//    Loads: be=4'hF, mem_we=0.
//  - load_type: B=k; H=addr[1]?6:4; W=7; BU=8+k; HU=addr[1]?13:12. Upper bits 0.
// TESTING
//  - LW addr=0x100, mem_ready after 3 cycles, rdata=0xDEADBEEF -> mem_addr=0x40; dmem_out=0xDEADBEEF;
//    load_type=7; done 1 cycle after ready.
//  - SB addr=0x203, store_data=0xA5 -> mem_be=4'b1000, mem_wdata=0xA5A5A5A5, mem_we=1; dmem_out unchanged.
//  - LHU addr=0x2 and LB addr=0x1 -> load_type 13 and 1; SH addr=0x2 -> be=4'b1100.
//  - LW addr=0x102 -> done next cycle, err_align=1, mem_req never asserted.
//  - TIMEOUT_CYCLES=4, mem_ready held 0 -> mem_req high exactly 4 cycles, then err_timeout=1 with done.
//  - Ready same cycle as req (zero wait) -> done at n+2.
//    start pulses while busy -> ignored.
//    rst_n low mid-REQ -> mem_req/busy 0 immediately, no done.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store controller between execute and data memory.
// Runs a req/ready handshake, flags misalignment and memory timeouts.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        err_align,
    output logic        err_timeout,
    output logic [31:0] dmem_out,
    output logic [6:0]  load_type,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_we;
    logic [29:0]      r_addr;
    logic [3:0]       r_be;
    logic [31:0]      r_wdata;
    logic [6:0]       r_lt;
    logic [31:0]      r_dmem;
    logic [6:0]       r_load_type;
    logic             r_err_align;
    logic             r_err_timeout;

    logic [1:0]       w_k;
    logic             w_fault;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [6:0]       w_lt;
    logic             w_hs;
    logic             w_set_align;
    logic             w_set_to;

    assign w_k = addr[1:0];

    // Alignment / illegal-size check on the incoming request
    always_comb begin
        w_fault = 1'b0;
        unique case (funct3)
            3'd0, 3'd4: w_fault = 1'b0;
            3'd1, 3'd5: w_fault = addr[0];
            3'd2:       w_fault = |addr[1:0];
            default:    w_fault = 1'b1;
        endcase
    end

    // Byte-lane enables and lane-replicated write data
    always_comb begin
        w_be    = 4'hF;
        w_wdata = 32'h0;
        if (is_store) begin
            unique case (funct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << w_k;
                    w_wdata = {4{store_data[7:0]}};
                end
                2'b01: begin
                    w_be    = addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{store_data[15:0]}};
                end
                default: begin
                    w_be    = 4'hF;
                    w_wdata = store_data;
                end
            endcase
        end
    end

    // Writeback parse code for the load
    always_comb begin
        w_lt = 7'd0;
        unique case (funct3)
            3'd0:    w_lt = {5'd0, w_k};
            3'd1:    w_lt = addr[1] ? 7'd6 : 7'd4;
            3'd2:    w_lt = 7'd7;
            3'd4:    w_lt = 7'd8 + {5'd0, w_k};
            3'd5:    w_lt = addr[1] ? 7'd13 : 7'd12;
            default: w_lt = 7'd0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and completion events
    always_comb begin
        w_next      = r_state;
        w_hs        = 1'b0;
        w_set_align = 1'b0;
        w_set_to    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next      = w_fault ? S_DONE : S_REQ;
                    w_set_align = w_fault;
                end
            end
            S_REQ: begin
                if (mem_ready) begin
                    w_hs   = 1'b1;
                    w_next = S_DONE;
                end else if (r_cnt == LAST) begin
                    w_set_to = 1'b1;
                    w_next   = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Count REQ cycles spent waiting for the memory
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (r_state == S_REQ && !mem_ready)
            r_cnt <= r_cnt + 1'b1;
        else
            r_cnt <= '0;
    end

    // Capture the request when it is accepted in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_lt    <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_we    <= is_store;
            r_addr  <= addr[31:2];
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_lt    <= w_lt;
        end
    end

    // Register the read word and its parse code on a load handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dmem      <= '0;
            r_load_type <= '0;
        end else if (w_hs && !r_we) begin
            r_dmem      <= mem_rdata;
            r_load_type <= r_lt;
        end
    end

    // Error flags live only for the DONE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_align   <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_err_align   <= w_set_align;
            r_err_timeout <= w_set_to;
        end
    end

    assign busy        = (r_state == S_REQ);
    assign mem_req     = (r_state == S_REQ);
    assign done        = (r_state == S_DONE);
    assign err_align   = r_err_align;
    assign err_timeout = r_err_timeout;
    assign dmem_out    = r_dmem;
    assign load_type   = r_load_type;
    assign mem_we      = r_we;
    assign mem_addr    = r_addr;
    assign mem_be      = r_be;
    assign mem_wdata   = r_wdata;

endmodule
